// File: rtl/calc_pkg.sv
// rtl/calc_pkg.sv - shared types and constants for the calculator operation sequencer
//
// Purpose : op encoding, sequencer state encoding, datapath width constants.
// Ports   : none (package).

package calc_pkg;

    localparam int WIDTH     = 8;
    localparam int MUL_ITERS = 8;

    typedef enum logic [1:0] {
        OP_ADD  = 2'b00,
        OP_SUB  = 2'b01,
        OP_MUL  = 2'b10,
        OP_RSVD = 2'b11
    } op_e;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        EXEC_ADD = 3'd1,
        SUB1     = 3'd2,
        SUB2     = 3'd3,
        MUL      = 3'd4,
        DONE     = 3'd5
    } state_e;

endpackage

// File: rtl/calc_op_sequencer.sv
// rtl/calc_op_sequencer.sv - multi-cycle ADD/SUB/MUL sequencer over a shared external adder
//
// Purpose : accepts an op + two operands, runs them through the shared 8-bit
//           adder (SUB as A+~B then +1, MUL as 8 shift-add passes) and
//           presents a registered result with valid/ready handshake.
// Ports   : clk, rst (sync, active-high)
//           in_valid/in_ready, op, opa, opb        - request side
//           out_valid/out_ready, result_lo/hi,carry - result side
//           add_a/add_b (to adder), add_s/add_c     - shared adder, same-cycle
//           zero, sovf                              - only with CALC_FLAGS_EN
// Macro   : CALC_FLAGS_EN adds the zero/sovf flag outputs.

module calc_op_sequencer #(
    parameter int WIDTH     = calc_pkg::WIDTH,
    parameter int MUL_ITERS = calc_pkg::MUL_ITERS
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] opa,
    input  logic [WIDTH-1:0] opb,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result_lo,
    output logic [WIDTH-1:0] result_hi,
    output logic             carry,
    output logic [WIDTH-1:0] add_a,
    output logic [WIDTH-1:0] add_b,
    input  logic [WIDTH-1:0] add_s,
    input  logic             add_c
`ifdef CALC_FLAGS_EN
   ,output logic             zero,
    output logic             sovf
`endif
);

    import calc_pkg::*;

    localparam int CNT_W = $clog2(MUL_ITERS);

    state_e             state_q;
    op_e                op_q;
    logic [WIDTH-1:0]   a_q, b_q;
    logic [WIDTH-1:0]   sub1_sum_q;
    logic               c1_q;
    logic [WIDTH-1:0]   acc_hi_q, mplr_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               in_ready_q, out_valid_q, carry_q;
    logic [WIDTH-1:0]   result_lo_q, result_hi_q;

    // Next shift-add step: the adder's carry becomes the new top bit of the
    // accumulator and the bit shifted out of the accumulator enters the multiplier.
    logic [WIDTH-1:0]   mul_hi_d, mul_lo_d;
    assign mul_hi_d = {add_c, add_s[WIDTH-1:1]};
    assign mul_lo_d = {add_s[0], mplr_q[WIDTH-1:1]};

    // Adder operands must be valid in the state's own cycle, so they are
    // decoded from the current state rather than registered.
    always_comb begin
        add_a = '0;
        add_b = '0;
        case (state_q)
            EXEC_ADD: begin add_a = a_q;        add_b = b_q;               end
            SUB1:     begin add_a = a_q;        add_b = ~b_q;              end
            SUB2:     begin add_a = sub1_sum_q; add_b = WIDTH'(1);         end
            MUL:      begin add_a = acc_hi_q;   add_b = mplr_q[0] ? a_q : '0; end
            default:  ;
        endcase
    end

`ifdef CALC_FLAGS_EN
    logic zero_q, sovf_q;
    assign zero = zero_q;
    assign sovf = sovf_q;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            op_q        <= OP_ADD;
            a_q         <= '0;
            b_q         <= '0;
            sub1_sum_q  <= '0;
            c1_q        <= 1'b0;
            acc_hi_q    <= '0;
            mplr_q      <= '0;
            cnt_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            carry_q     <= 1'b0;
            result_lo_q <= '0;
            result_hi_q <= '0;
`ifdef CALC_FLAGS_EN
            zero_q      <= 1'b0;
            sovf_q      <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        op_q       <= op_e'(op);
                        a_q        <= opa;
                        b_q        <= opb;
                        acc_hi_q   <= '0;
                        mplr_q     <= opb;
                        cnt_q      <= '0;
                        in_ready_q <= 1'b0;
                        case (op_e'(op))
                            OP_SUB:  state_q <= SUB1;
                            OP_MUL:  state_q <= MUL;
                            default: state_q <= EXEC_ADD;
                        endcase
                    end
                end
                EXEC_ADD: begin
                    // Reserved op shares ADD timing but reports an all-zero result.
                    result_lo_q <= (op_q == OP_RSVD) ? '0 : add_s;
                    result_hi_q <= '0;
                    carry_q     <= (op_q == OP_RSVD) ? 1'b0 : add_c;
`ifdef CALC_FLAGS_EN
                    zero_q      <= (op_q == OP_RSVD) ? 1'b1 : (add_s == '0);
                    sovf_q      <= (op_q != OP_RSVD) && (a_q[WIDTH-1] == b_q[WIDTH-1])
                                   && (add_s[WIDTH-1] != a_q[WIDTH-1]);
`endif
                    out_valid_q <= 1'b1;
                    state_q     <= DONE;
                end
                SUB1: begin
                    sub1_sum_q <= add_s;
                    c1_q       <= add_c;
                    state_q    <= SUB2;
                end
                SUB2: begin
                    // No-borrow is set if either pass carried out.
                    result_lo_q <= add_s;
                    result_hi_q <= '0;
                    carry_q     <= c1_q | add_c;
`ifdef CALC_FLAGS_EN
                    zero_q      <= (add_s == '0);
                    sovf_q      <= (a_q[WIDTH-1] != b_q[WIDTH-1])
                                   && (add_s[WIDTH-1] != a_q[WIDTH-1]);
`endif
                    out_valid_q <= 1'b1;
                    state_q     <= DONE;
                end
                MUL: begin
                    acc_hi_q <= mul_hi_d;
                    mplr_q   <= mul_lo_d;
                    cnt_q    <= cnt_q + 1'b1;
                    if (cnt_q == CNT_W'(MUL_ITERS - 1)) begin
                        result_lo_q <= mul_lo_d;
                        result_hi_q <= mul_hi_d;
                        carry_q     <= (mul_hi_d != '0);
`ifdef CALC_FLAGS_EN
                        zero_q      <= ({mul_hi_d, mul_lo_d} == '0);
                        sovf_q      <= 1'b0;
`endif
                        out_valid_q <= 1'b1;
                        state_q     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign result_lo = result_lo_q;
    assign result_hi = result_hi_q;
    assign carry     = carry_q;

endmodule
